// File: rtl/uart_tx_framer.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_framer
// Description : Serialises one parallel word per request into a UART frame
//               (start, LSB-first data, optional parity, stop), one bit/CLK.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_framer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  busy
);

  localparam int IDX_W = $clog2(DATA_WIDTH);
  localparam logic [IDX_W-1:0] c_idx_last = IDX_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;

  logic [IDX_W-1:0]      w_idx_nxt;
  logic                  w_parity;

  assign w_idx_nxt = idx_q + IDX_W'(1);
  // Parity comes from the captured word so later P_DATA changes cannot leak in.
  assign w_parity  = (^data_q) ^ par_typ_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      data_q    <= data_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

  // Outputs are computed for the state being entered, so the flops present
  // each bit on the same edge that enters its state.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    data_d    = data_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    tx_d      = 1'b1;
    busy_d    = 1'b1;
    unique case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (DATA_VALID) begin
          state_d   = START;
          data_d    = P_DATA;
          par_en_d  = PAR_EN;
          par_typ_d = PAR_TYP;
          tx_d      = 1'b0;
          busy_d    = 1'b1;
        end
      end
      START: begin
        state_d = DATA;
        idx_d   = '0;
        tx_d    = data_q[0];
      end
      DATA: begin
        if (idx_q == c_idx_last) begin
          if (par_en_q) begin
            state_d = PARITY;
            tx_d    = w_parity;
          end else begin
            state_d = STOP;
          end
        end else begin
          idx_d = w_idx_nxt;
          tx_d  = data_q[w_idx_nxt];
        end
      end
      PARITY: begin
        state_d = STOP;
      end
      STOP: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign TX_OUT = tx_q;
  assign busy   = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_framer.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_framer
// Description : Self-checking bench for uart_tx_framer; expected frames are
//               built from the UART framing rules and compared bit by bit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_framer;

  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         RST = 1'b0;
  logic [W-1:0] P_DATA = '0;
  logic         DATA_VALID = 1'b0;
  logic         PAR_EN = 1'b0;
  logic         PAR_TYP = 1'b0;
  logic         TX_OUT;
  logic         busy;

  int n_checks = 0;
  int n_errors = 0;

  uart_tx_framer #(.DATA_WIDTH(W)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .P_DATA    (P_DATA),
    .DATA_VALID(DATA_VALID),
    .PAR_EN    (PAR_EN),
    .PAR_TYP   (PAR_TYP),
    .TX_OUT    (TX_OUT),
    .busy      (busy)
  );

  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Entered at the negedge where the start bit should be visible; returns at
  // the negedge where the stop bit was checked.
  task automatic observe_frame(input string name, input logic [W-1:0] d,
                               input logic pe, input logic pt, input bit noise);
    bit q[$];
    q.push_back(1'b0);
    for (int i = 0; i < W; i++) q.push_back(d[i]);
    if (pe) q.push_back((($countones(d) % 2) == 1) ^ pt);
    q.push_back(1'b1);
    for (int i = 0; i < q.size(); i++) begin
      if (i > 0) @(negedge CLK);
      check_val($sformatf("%s tx[%0d]", name, i), {31'd0, TX_OUT}, {31'd0, q[i]});
      check_val($sformatf("%s busy[%0d]", name, i), {31'd0, busy}, 32'd1);
      if (noise) begin
        P_DATA  = W'($urandom);
        PAR_EN  = 1'($urandom);
        PAR_TYP = 1'($urandom);
        DATA_VALID = (i < q.size() - 1) ? 1'($urandom) : 1'b0;
      end
    end
  endtask

  task automatic check_idle(input string name);
    check_val({name, " idle tx"}, {31'd0, TX_OUT}, 32'd1);
    check_val({name, " idle busy"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic send(input string name, input logic [W-1:0] d, input logic pe,
                      input logic pt, input bit noise);
    @(negedge CLK);
    P_DATA = d; PAR_EN = pe; PAR_TYP = pt; DATA_VALID = 1'b1;
    @(negedge CLK);
    DATA_VALID = 1'b0;
    observe_frame(name, d, pe, pt, noise);
    DATA_VALID = 1'b0;
    @(negedge CLK);
    check_idle(name);
    @(negedge CLK);
    check_idle({name, "+1"});
  endtask

  initial begin
    logic [W-1:0] rd;
    logic         rpe, rpt;

    #12;
    check_idle("reset");
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    check_idle("post-reset");

    send("even_a5", 8'hA5, 1'b1, 1'b0, 1'b0);
    send("odd_a5",  8'hA5, 1'b1, 1'b1, 1'b0);
    send("nopar_3c", 8'h3C, 1'b0, 1'b0, 1'b0);

    // Mid-frame input churn: captured word must survive, no extra frame.
    @(negedge CLK);
    P_DATA = 8'h5A; PAR_EN = 1'b1; PAR_TYP = 1'b0; DATA_VALID = 1'b1;
    @(negedge CLK);
    DATA_VALID = 1'b0;
    fork
      observe_frame("churn", 8'h5A, 1'b1, 1'b0, 1'b0);
      begin
        repeat (3) @(negedge CLK);
        P_DATA = 8'hFF; PAR_TYP = 1'b1; DATA_VALID = 1'b1;
        @(negedge CLK);
        DATA_VALID = 1'b0;
      end
    join
    @(negedge CLK);
    check_idle("churn");
    @(negedge CLK);
    check_idle("churn+1");

    // Held DATA_VALID across two frames: exactly one idle cycle between.
    @(negedge CLK);
    P_DATA = 8'h00; PAR_EN = 1'b0; PAR_TYP = 1'b0; DATA_VALID = 1'b1;
    @(negedge CLK);
    P_DATA = 8'hFF;
    observe_frame("held0", 8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge CLK);
    check_idle("held gap");
    @(negedge CLK);
    DATA_VALID = 1'b0;
    P_DATA = 8'h12;
    observe_frame("held1", 8'hFF, 1'b0, 1'b0, 1'b0);
    @(negedge CLK);
    check_idle("held end");

    // Reset during data bit 3, then a frame accepted on the first edge after release.
    @(negedge CLK);
    P_DATA = 8'hC3; PAR_EN = 1'b1; PAR_TYP = 1'b0; DATA_VALID = 1'b1;
    @(negedge CLK);
    DATA_VALID = 1'b0;
    repeat (4) @(negedge CLK);
    check_val("rst pre tx", {31'd0, TX_OUT}, 32'd0);
    #1 RST = 1'b0;
    #1;
    check_val("rst async tx", {31'd0, TX_OUT}, 32'd1);
    check_val("rst async busy", {31'd0, busy}, 32'd0);
    repeat (2) @(negedge CLK);
    check_idle("rst held");
    P_DATA = 8'h81; PAR_EN = 1'b1; PAR_TYP = 1'b1; DATA_VALID = 1'b1;
    RST = 1'b1;
    @(negedge CLK);
    DATA_VALID = 1'b0;
    observe_frame("after_rst", 8'h81, 1'b1, 1'b1, 1'b0);
    @(negedge CLK);
    check_idle("after_rst");

    for (int k = 0; k < 24; k++) begin
      rd  = W'($urandom);
      rpe = 1'($urandom);
      rpt = 1'($urandom);
      send($sformatf("rand%0d", k), rd, rpe, rpt, 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
